// File: rtl/btn_pkg.sv
// btn_pkg: definitions shared by the button conditioning front end.
//   - Channel state encoding (IDLE / PRESSED / LONG) and its enum type.
//   - Board button index constants, matching the bit order of btn_raw_i.
package btn_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] LONG    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_PRESSED = PRESSED,
    ST_LONG    = LONG
  } ch_state_t;

  localparam int BTN_RESET  = 0;
  localparam int BTN_CANCEL = 1;
  localparam int BTN_TEST   = 2;
  localparam int BTN_ACTION = 3;
  localparam int BTN_LEFT   = 4;
  localparam int BTN_RIGHT  = 5;

endpackage

// File: rtl/button_channel.sv
// button_channel: conditioning for one pushbutton bit.
//   Two-flop synchroniser, tick-based debounce, and a small FSM that emits
//   a press pulse, a long-press pulse and a registered hold level.
// Ports:
//   clk, rst    - system clock, asynchronous active-high reset
//   tick        - shared 1 ms strobe (one cycle wide)
//   btn_raw     - raw pin level
//   press       - one-cycle pulse on debounced press
//   long_pulse  - one-cycle pulse when the hold reaches LONG_MS ticks
//   held        - debounced pressed level, registered
module button_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 5000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic press,
  output logic long_pulse,
  output logic held
);

  localparam int   DW           = $clog2(DEBOUNCE_MS + 1);
  localparam int   HW           = $clog2(LONG_MS + 1);
  // Pin level that means "not pressed"; the sync flops reset to this.
  localparam logic RELEASED_PIN = (ACTIVE_LOW != 0);

  logic            sync_p0;
  logic            sync_p1;
  logic            pressed_p1;
  logic            db_level;
  logic [DW-1:0]   db_cnt;
  logic [HW-1:0]   hold_cnt;
  ch_state_t       state;

  // Stage p0/p1: two-flop synchroniser; only sync_p1 is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= RELEASED_PIN;
      sync_p1 <= RELEASED_PIN;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign pressed_p1 = sync_p1 ^ RELEASED_PIN;

  // Debounce: count ticks while the synced value disagrees with the
  // debounced level. The counter is cleared on the tick that would reach
  // DEBOUNCE_MS, so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (pressed_p1 == db_level) begin
      db_cnt <= '0;
    end else if (tick) begin
      if (db_cnt == DW'(DEBOUNCE_MS - 1)) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  // Channel FSM with registered outputs. A debounced fall takes priority
  // over a tick arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      press      <= 1'b0;
      long_pulse <= 1'b0;
      held       <= 1'b0;
    end else begin
      press      <= 1'b0;
      long_pulse <= 1'b0;
      held       <= db_level;
      unique case (state)
        ST_IDLE: begin
          hold_cnt <= '0;
          if (db_level) begin
            state <= ST_PRESSED;
            press <= 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!db_level) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (hold_cnt == HW'(LONG_MS - 1)) begin
              state      <= ST_LONG;
              long_pulse <= 1'b1;
              hold_cnt   <= HW'(LONG_MS);
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        ST_LONG: begin
          // Counter frozen at LONG_MS; wait for release.
          if (!db_level) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: input stage for the pet FSM.
//   Generates the 1 ms tick and conditions each raw button into clean
//   press / long-press pulses and a debounced hold level in the clk domain.
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   btn_raw_i    - raw pins: 0 reset, 1 cancel, 2 test, 3 action, 4 left, 5 right
//   press_o      - one-cycle pulse per debounced press
//   long_o       - one-cycle pulse when a hold reaches LONG_MS
//   held_o       - debounced pressed level
//   tick_1ms_o   - one-cycle strobe every CLK_HZ/1000 cycles
module button_conditioner
  import btn_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int N_BTN       = 6,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 5000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] long_o,
  output logic [N_BTN-1:0] held_o,
  output logic             tick_1ms_o
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  generate
    if (DEBOUNCE_MS < 1 || LONG_MS <= DEBOUNCE_MS || TICK_DIV < 1) begin : g_bad_params
      $error("button_conditioner: need DEBOUNCE_MS >= 1, LONG_MS > DEBOUNCE_MS, CLK_HZ >= 1000");
    end
  endgenerate

  logic [PW-1:0] presc;

  // Prescaler: the tick is high in the cycle where the count has wrapped
  // to 0, so the first tick lands TICK_DIV cycles after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      tick_1ms_o <= 1'b0;
    end else if (presc == PW'(TICK_DIV - 1)) begin
      presc      <= '0;
      tick_1ms_o <= 1'b1;
    end else begin
      presc      <= presc + PW'(1);
      tick_1ms_o <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick_1ms_o),
      .btn_raw    (btn_raw_i[i]),
      .press      (press_o[i]),
      .long_pulse (long_o[i]),
      .held       (held_o[i])
    );
  end

endmodule
